serial_tx_arbiter: RTL

Round-robin transmit controller that shares one serial line among `NUM_REQ` parallel-word requesters. Each granted word is framed with the 6-bit start sequence 0,1,1,0,1,0 and then shifted out MSB-first over `DATA_WIDTH` contiguous cycles. The frame format matches the team's serial receiver, which detects that start sequence and asserts its valid window for exactly 32 cycles. The block sits between the local producers and the serial pin and owns all line sequencing and idle spacing.

---
 rtl/serial_tx_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/serial_tx_arbiter.sv
// Round-robin serial transmitter: frames each granted word with a 6-bit start
// sequence, shifts it out MSB-first, then inserts idle gap cycles.
module serial_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          serData,
  output logic                          data_phase,
  output logic                          frame_done,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // Bit i is sent in the i-th preamble cycle: 0,1,1,0,1,0.
  localparam logic [7:0]    PREAMBLE_BITS = 8'b0001_0110;
  localparam logic [CW-1:0] DATA_LAST     = CW'(DATA_WIDTH - 1);
  localparam logic [PW-1:0] GAP_LAST      = PW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GAP} state_t;

  state_t                state, state_n;
  logic [2:0]            pre_cnt, pre_cnt_n;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic [PW-1:0]         gap_cnt, gap_cnt_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [GW-1:0]         last_grant, last_grant_n, grant_id_n;
  logic [GW-1:0]         winner;
  logic                  found;
  logic                  line_n, data_phase_n, frame_done_n, busy_n;

  always_comb begin
    int unsigned idx;
    idx    = 0;
    found  = 1'b0;
    winner = last_grant;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  always_comb begin
    state_n      = state;
    pre_cnt_n    = pre_cnt;
    bit_cnt_n    = bit_cnt;
    gap_cnt_n    = gap_cnt;
    shreg_n      = shreg;
    last_grant_n = last_grant;
    grant_id_n   = grant_id;
    req_ready    = '0;
    unique case (state)
      IDLE: begin
        if (found && !rst) begin
          req_ready[winner] = 1'b1;
          shreg_n           = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
          last_grant_n      = winner;
          grant_id_n        = winner;
          pre_cnt_n         = '0;
          state_n           = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (pre_cnt == 3'd5) begin
          bit_cnt_n = '0;
          state_n   = DATA;
        end else begin
          pre_cnt_n = pre_cnt + 3'd1;
        end
      end
      DATA: begin
        shreg_n = shreg << 1;
        if (bit_cnt == DATA_LAST) begin
          if (GAP_CYCLES == 0) begin
            state_n = IDLE;
          end else begin
            gap_cnt_n = '0;
            state_n   = GAP;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = IDLE;
        else gap_cnt_n = gap_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered
    // while still lining up with the state they describe.
    line_n = 1'b1;
    if (state_n == PREAMBLE) line_n = PREAMBLE_BITS[pre_cnt_n];
    else if (state_n == DATA) line_n = shreg_n[DATA_WIDTH-1];
    data_phase_n = (state_n == DATA);
    frame_done_n = (state_n == DATA) && (bit_cnt_n == DATA_LAST);
    busy_n       = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shreg      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      grant_id   <= '0;
      serData    <= 1'b1;
      data_phase <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      pre_cnt    <= pre_cnt_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      shreg      <= shreg_n;
      last_grant <= last_grant_n;
      grant_id   <= grant_id_n;
      serData    <= line_n;
      data_phase <= data_phase_n;
      frame_done <= frame_done_n;
      busy       <= busy_n;
    end
  end
endmodule
